// File: rtl/aes_spi_responder_if.sv
// Serial link between the Master and the AES responder: frame input plus result output.
interface aes_spi_responder_if;
  logic cs;        // chip select, active-high
  logic Mosi;      // frame bits, MSB first
  logic in_valid;  // qualifies Mosi
  logic Miso;      // result bits, MSB first
  logic out_valid; // high while Miso carries a result bit

  modport master (output cs, Mosi, in_valid, input Miso, out_valid);
  modport slave  (input cs, Mosi, in_valid, output Miso, out_valid);
endinterface

// File: rtl/aes_spi_responder.sv
// Serial responder for an AES core: deserializes a message+key frame, launches
// the core, waits for its result and serializes the 128-bit result back.
module aes_spi_responder #(
  parameter int nk = 4,   // key length in 32-bit words
  parameter int nb = 4,   // block length in 32-bit words
  parameter int nr = 10   // round count of the attached core, informational
) (
  input  logic                 clk,
  input  logic                 rst,          // asynchronous, active-low
  aes_spi_responder_if.slave   spi,
  output logic [32*nb-1:0]     core_msg,
  output logic [32*nk-1:0]     core_key,
  output logic                 core_start,
  input  logic                 core_done,
  input  logic [32*nb-1:0]     core_result,
  output logic                 busy
);
  localparam int BW = 32 * nb;
  localparam int KW = 32 * nk;
  localparam int F  = BW + KW;
  localparam int CW = $clog2(F + 1);
  localparam logic [CW-1:0] RX_LAST = CW'(F - 1);
  localparam logic [CW-1:0] TX_LAST = CW'(BW - 1);

  // nr only documents which core is attached; the guard keeps it referenced.
  if (nb != 4 || nr < 1) begin : g_unsupported_params
  end

  typedef enum logic [2:0] {S_IDLE, S_RX, S_START, S_WAIT, S_TX} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [F-2:0]    rx_q, rx_d;       // holds all but the final bit of a frame
  logic [BW-1:0]   tx_q, tx_d;
  logic [BW-1:0]   msg_q, msg_d;
  logic [KW-1:0]   key_q, key_d;
  logic            start_q, start_d;

  logic            take_bit;
  logic            frame_done;
  logic [F-1:0]    rx_shifted;

  assign take_bit   = spi.cs & spi.in_valid;
  assign rx_shifted = {rx_q, spi.Mosi};
  assign frame_done = (state_q == S_RX) && take_bit && (cnt_q == RX_LAST);

  // State and datapath registers; reset returns everything to an idle, zeroed block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      msg_q   <= '0;
      key_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      msg_q   <= msg_d;
      key_q   <= key_d;
      start_q <= start_d;
    end
  end

  // Next-state logic; dropping cs aborts any active phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (take_bit) state_d = S_RX;
      S_RX: begin
        if (!spi.cs)         state_d = S_IDLE;
        else if (frame_done) state_d = S_START;
      end
      S_START: state_d = spi.cs ? S_WAIT : S_IDLE;
      S_WAIT: begin
        if (!spi.cs)        state_d = S_IDLE;
        else if (core_done) state_d = S_TX;
      end
      S_TX:    if (!spi.cs || cnt_q == TX_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates: shift-in, frame load, launch pulse, result capture and shift-out.
  always_comb begin
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    msg_d   = msg_q;
    key_d   = key_q;
    start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (take_bit) begin
          rx_d  = rx_shifted[F-2:0];
          cnt_d = CW'(1);
        end
      end
      S_RX: begin
        if (!spi.cs) begin
          cnt_d = '0;
        end else if (spi.in_valid) begin
          rx_d  = rx_shifted[F-2:0];
          cnt_d = cnt_q + 1'b1;
          // Core-facing words change only when a whole frame has arrived.
          if (frame_done) begin
            msg_d = rx_shifted[F-1 -: BW];
            key_d = rx_shifted[KW-1:0];
            cnt_d = '0;
          end
        end
      end
      S_START: start_d = spi.cs;   // suppressed if the frame is aborted here
      S_WAIT: begin
        if (spi.cs && core_done) begin
          tx_d  = core_result;
          cnt_d = '0;
        end
      end
      S_TX: begin
        if (!spi.cs) begin
          cnt_d = '0;
        end else begin
          tx_d  = {tx_q[BW-2:0], 1'b0};
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // Outputs; Miso is forced low whenever no result bit is being presented.
  always_comb begin
    spi.out_valid = (state_q == S_TX);
    spi.Miso      = (state_q == S_TX) & tx_q[BW-1];
    busy          = (state_q != S_IDLE);
    core_start    = start_q;
    core_msg      = msg_q;
    core_key      = key_q;
  end
endmodule

// File: tb/tb_aes_spi_responder.sv
// Directed + randomized bench for aes_spi_responder (nk=4 and nk=8 instances).
module tb_aes_spi_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         sel;        // 0: nk=4 instance, 1: nk=8 instance
  logic         cs_drv, mosi_drv, iv_drv, done_drv;
  logic [127:0] result_drv;

  int checks = 0;
  int errors = 0;

  aes_spi_responder_if ifa ();
  aes_spi_responder_if ifb ();

  assign ifa.cs       = cs_drv & ~sel;
  assign ifa.Mosi     = mosi_drv;
  assign ifa.in_valid = iv_drv;
  assign ifb.cs       = cs_drv & sel;
  assign ifb.Mosi     = mosi_drv;
  assign ifb.in_valid = iv_drv;

  logic [127:0] msg_a, msg_b;
  logic [127:0] key_a;
  logic [255:0] key_b;
  logic         start_a, start_b, busy_a, busy_b;

  aes_spi_responder #(.nk(4), .nb(4), .nr(10)) dut_a (
    .clk(clk), .rst(rst), .spi(ifa),
    .core_msg(msg_a), .core_key(key_a), .core_start(start_a),
    .core_done(done_drv & ~sel), .core_result(result_drv), .busy(busy_a)
  );

  aes_spi_responder #(.nk(8), .nb(4), .nr(14)) dut_b (
    .clk(clk), .rst(rst), .spi(ifb),
    .core_msg(msg_b), .core_key(key_b), .core_start(start_b),
    .core_done(done_drv & sel), .core_result(result_drv), .busy(busy_b)
  );

  wire          miso_o  = sel ? ifb.Miso : ifa.Miso;
  wire          ov_o    = sel ? ifb.out_valid : ifa.out_valid;
  wire          busy_o  = sel ? busy_b : busy_a;
  wire          start_o = sel ? start_b : start_a;
  wire [127:0]  msg_o   = sel ? msg_b : msg_a;
  wire [255:0]  key_o   = sel ? key_b : {128'd0, key_a};

  // Reference state: the last frame the responder should have handed to the core.
  logic [127:0] last_m;
  logic [255:0] last_k;

  task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand256();
    return {rand128(), rand128()};
  endfunction

  // Sends message then key MSB first; gapped drops in_valid every third cycle;
  // stop_after>0 drops cs after that many qualified bits.
  task automatic send_frame(input logic [127:0] m, input logic [255:0] k,
                            input bit gapped, input int stop_after);
    logic [383:0] fr;
    logic [255:0] kexp;
    int f, i, cyc, sent;
    bit busy_chk, early_start;
    f    = sel ? 384 : 256;
    fr   = sel ? {m, k} : {128'd0, m, k[127:0]};
    kexp = sel ? k : {128'd0, k[127:0]};
    i = f - 1; cyc = 0; sent = 0; busy_chk = 0; early_start = 0;
    while (i >= 0) begin
      @(negedge clk);
      if (start_o) early_start = 1;
      if (sent == 1 && !busy_chk) begin
        check("busy_after_first_bit", busy_o, 1);
        busy_chk = 1;
      end
      if (stop_after > 0 && sent == stop_after) begin
        cs_drv = 0; iv_drv = 0;
        break;
      end
      cs_drv = 1;
      if (gapped && (cyc % 3 == 2)) begin
        iv_drv = 0; mosi_drv = 1'($urandom);
      end else begin
        iv_drv = 1; mosi_drv = fr[i]; i--; sent++;
      end
      cyc++;
    end
    if (stop_after == 0) begin
      @(negedge clk);                 // last bit sampled at edge N
      iv_drv = 0; mosi_drv = 0;
      check("no_start_during_rx", early_start, 0);
      check("core_msg", msg_o, m);
      check("core_key", key_o, kexp);
      check("start_low_at_N", start_o, 0);
      @(negedge clk);
      check("start_high_N+1", start_o, 1);
      @(negedge clk);
      check("start_low_N+2", start_o, 0);
      last_m = m; last_k = kexp;
    end
  endtask

  // Acts as the core: returns res after lat cycles, then reassembles Miso.
  // abort_at>=0 applies reset after that many result bits.
  task automatic get_result(input logic [127:0] res, input int lat, input int abort_at);
    logic [127:0] got;
    bit ov_ok, ov_wait;
    ov_ok = 1; ov_wait = 0; got = '0;
    repeat (lat) begin
      @(negedge clk);
      if (ov_o) ov_wait = 1;
      iv_drv = 1; mosi_drv = 1'($urandom);   // ignored while waiting
    end
    check("no_out_valid_in_wait", ov_wait, 0);
    done_drv = 1; result_drv = res;
    for (int j = 0; j < 128; j++) begin
      @(negedge clk);
      if (j == 0) begin
        done_drv = 0; result_drv = rand128();
        check("first_bit_is_127", {ov_o, miso_o}, {1'b1, res[127]});
      end
      if (j == abort_at) begin
        #2 rst = 0;
        #1;
        check("async_reset_clears", {miso_o, ov_o, busy_o, start_o, msg_o, key_o}, '0);
        iv_drv = 0; cs_drv = 0;
        return;
      end
      if (!ov_o) ov_ok = 0;
      got = {got[126:0], miso_o};
      iv_drv = 1; mosi_drv = 1'($urandom);   // ignored while transmitting
    end
    @(negedge clk);
    iv_drv = 0; mosi_drv = 0;
    check("out_valid_contiguous", ov_ok, 1);
    check("result_stream", got, res);
    check("end_of_tx", {ov_o, busy_o, miso_o}, 3'b000);
    $display("txn sel=%0d result=%h got=%h", sel, res, got);
  endtask

  initial begin
    logic [127:0] m, r;
    logic [255:0] k;
    bit stray;
    rst = 0; sel = 0; cs_drv = 0; mosi_drv = 0; iv_drv = 0; done_drv = 0; result_drv = '0;
    last_m = '0; last_k = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {miso_o, ov_o, busy_o, start_o, msg_o, key_o}, '0);
    rst = 1;
    @(negedge clk);

    // Known-answer frame, continuous in_valid
    send_frame(128'h00112233445566778899aabbccddeeff,
               {128'd0, 128'h000102030405060708090a0b0c0d0e0f}, 0, 0);
    get_result(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 20, -1);

    // Same frame, gapped
    send_frame(128'h00112233445566778899aabbccddeeff,
               {128'd0, 128'h000102030405060708090a0b0c0d0e0f}, 1, 0);
    get_result(rand128(), $urandom_range(1, 30), -1);

    // Stray core_done while idle
    cs_drv = 0;
    @(negedge clk); done_drv = 1; result_drv = rand128();
    @(negedge clk); done_drv = 0;
    stray = 0;
    repeat (4) begin @(negedge clk); if (ov_o || busy_o) stray = 1; end
    check("stray_done_idle", stray, 0);

    // Abort in RX after 60 bits
    send_frame(rand128(), {128'd0, rand128()}, 0, 60);
    @(negedge clk);
    check("abort_busy_low", busy_o, 0);
    stray = 0;
    repeat (5) begin @(negedge clk); if (start_o) stray = 1; end
    check("abort_no_start", stray, 0);
    check("abort_keeps_msg", msg_o, last_m);
    check("abort_keeps_key", key_o, last_k);
    send_frame(128'hc9ec0c24fad05d6fec9516ebee689c53,
               {128'd0, 128'he5b3bff1eb0c99fcee48f846b250aea0}, 0, 0);
    get_result(rand128(), 7, -1);

    // Reset in the middle of the result stream
    send_frame(rand128(), {128'd0, rand128()}, 0, 0);
    get_result(rand128(), 5, 40);
    repeat (2) @(negedge clk);
    rst = 1;
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if ({miso_o, ov_o, busy_o, start_o} != 4'b0) stray = 1;
    end
    check("quiet_after_reset", stray, 0);
    send_frame(rand128(), {128'd0, rand128()}, 0, 0);
    get_result(rand128(), 3, -1);

    // Randomized frames on the nk=4 instance
    for (int t = 0; t < 3; t++) begin
      m = rand128(); k = {128'd0, rand128()}; r = rand128();
      send_frame(m, k, 1'($urandom), 0);
      get_result(r, $urandom_range(1, 25), -1);
    end

    // nk=8 instance: 384-bit frames
    cs_drv = 0;
    @(negedge clk);
    sel = 1;
    @(negedge clk);
    for (int t = 0; t < 2; t++) begin
      m = rand128(); k = rand256(); r = rand128();
      send_frame(m, k, t[0], 0);
      get_result(r, $urandom_range(1, 25), -1);
    end

    cs_drv = 0;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_spi_responder.md
# aes_spi_responder

Serial responder for the AES cipher units. It sits between a serial Master and a parallel AES core (encrypt or decrypt). It shifts in a message and key frame from the Master, launches the core, waits for the result, and shifts the 128-bit result back out to the Master. It is the slave-side counterpart of the Master's serializer/deserializer, so cipher units no longer need their own serial logic.

## Interface
Parameters:
- nk, 4, key length in 32-bit words (4/6/8 → 128/192/256-bit key)
- nb, 4, block size in 32-bit words (fixed 4; block = 128 bits)
- nr, 10, round count; passed through for documentation only, not used by this block

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- cs  in  1  chip select from Master, active-high
- Mosi  in  1  serial data from Master, MSB first
- in_valid  in  1  Master qualifier; a Mosi bit is taken only when cs=1 and in_valid=1
- Miso  out  1  serial result to Master, MSB first
- out_valid  out  1  high on every cycle Miso carries a result bit
- core_msg  out  128  message word to core
- core_key  out  32*nk  key word to core
- core_start  out  1  single-cycle launch pulse
- core_done  in  1  core completion strobe, one cycle
- core_result  in  128  core output; valid while core_done=1
- busy  out  1  high whenever state ≠ IDLE

## Operation
- Frame length F = 128 + 32*nk bits. Order on Mosi: message[127] … message[0], then key[32*nk-1] … key[0].
- Bit counter width is $clog2(F+1). Bits accumulate in an internal shift register. core_msg and core_key load from it only when a frame completes, so a partial frame never alters them.
- States:
  - IDLE
    - cs=1 and in_valid=1 → RX; that first bit is captured; counter=1.
  - RX
    - Each qualified bit shifts in and increments the counter.
    - in_valid=0 with cs=1 → hold; nothing shifts.
    - On the F-th bit: load core_msg/core_key on that edge, then go to START.
  - START
    - core_start=1 for exactly one cycle, then WAIT.
  - WAIT
    - Mosi and in_valid are ignored.
    - core_done=1 → latch core_result into the TX shift register and go to TX.
  - TX
    - out_valid=1 and Miso=current MSB; shift left each cycle for 128 cycles.
    - After the 128th bit, go to IDLE with out_valid=0.
- Abort: cs=0 in RX, START, WAIT or TX → IDLE on the next edge. Partial data is discarded; core_start is not issued if still pending; out_valid and Miso drop to 0. The core is not cancelled. A later core_done arriving in IDLE or RX is ignored.
- core_done in any state other than WAIT is ignored.
- Miso=0 whenever out_valid=0.

## Timing
- Reset (rst=0, asynchronous) clears the following to 0: state=IDLE, counter, shift registers, Miso, out_valid, core_start, busy, core_msg, core_key.
- Reset mid-operation aborts immediately, with no residual pulse after release.
- Let the last frame bit be sampled at edge N.
  - core_msg/core_key are valid from edge N.
  - core_start is high from edge N+1 to edge N+2.
  - busy is high from the edge that captures the first bit.
- Let core_done be sampled high at edge D.
  - Bit 127 appears on Miso with out_valid=1 after edge D.
  - Bit k appears after edge D+(127-k).
  - out_valid falls and busy falls after edge D+128.
- Minimum turnaround is F + 1 + core latency + 128 cycles.
- A new frame may begin the cycle after return to IDLE.

## Test plan
- Full frame with nk=4: message 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, sent over 256 continuous in_valid cycles.
  - core_msg/core_key match exactly.
  - core_start high for exactly one cycle, one cycle after the last bit.
  - A model core returns 69c4e0d86a7b0430d8cdb78070b4c55a after 20 cycles; 128 Miso bits reassemble to that value with out_valid contiguous.
- Gapped input: the same frame with in_valid low on every third cycle.
  - Identical core_msg/core_key.
  - core_start timing measured relative to the last qualified bit.
- Abort in RX: cs drops after 60 bits.
  - No core_start; core_msg/core_key keep their previous values; busy returns to 0.
  - A following full frame (message c9ec0c24fad05d6fec9516ebee689c53, key e5b3bff1eb0c99fcee48f846b250aea0) completes correctly.
- Stray and ignored inputs:
  - core_done pulsed in IDLE → no out_valid.
  - Mosi toggling with in_valid=1 during WAIT and TX → the result stream is unaffected.
- Reset mid-TX: rst=0 after 40 result bits.
  - All outputs 0 asynchronously and stay 0 after release.
  - The next frame works.
- nk=8 build: 384-bit frame.
  - Key order verified on core_key[255:0].
  - core_start one cycle after bit 384.
